// File: rtl/flex_stp_pkg.sv
// Shared definitions for the flexible serial-to-parallel deserialiser:
// shift-direction encodings and the word-length clamp.
package flex_stp_pkg;

   localparam logic DIR_MSB = 1'b1;
   localparam logic DIR_LSB = 1'b0;

   // A length of zero or one beyond the register width means "full width".
   function automatic int sanitise_len(input int word_len, input int num_bits);
      if ((word_len == 0) || (word_len > num_bits)) begin
         return num_bits;
      end else begin
         return word_len;
      end
   endfunction

endpackage

// File: rtl/flex_stp_hold.sv
// One-entry valid/ready holding register. A word arriving while the slot
// is full and not being drained is dropped and flagged with a one-cycle overrun.
module flex_stp_hold
   import flex_stp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             overrun_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;

   // Holding-register state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         data_q  <= {WIDTH{1'b0}};
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   // Load, drain, or drop-with-overrun; clear empties the slot but keeps the data.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         if (!valid_q || ready_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign overrun_o = ovr_q;

endmodule

// File: rtl/flex_stp_deser.sv
// Run-time configurable serial-to-parallel deserialiser with word framing
// and a one-entry valid/ready output stage.
module flex_stp_deser
   import flex_stp_pkg::*;
#(
   parameter  int   NUM_BITS  = 8,
   parameter  logic RESET_BIT = 1'b1,
   localparam int   CNT_W     = $clog2(NUM_BITS + 1)
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                clear,
   input  logic                shift_enable,
   input  logic                serial_in,
   input  logic                msb_first,
   input  logic [CNT_W-1:0]    word_len,
   input  logic                word_ready,
   output logic [NUM_BITS-1:0] parallel_live,
   output logic [CNT_W-1:0]    bit_cnt,
   output logic [NUM_BITS-1:0] word_out,
   output logic                word_valid,
   output logic                overrun
);

   localparam logic [NUM_BITS-1:0] SR_RESET  = {NUM_BITS{RESET_BIT}};
   localparam logic [CNT_W-1:0]    LEN_RESET = CNT_W'(NUM_BITS);

   logic [NUM_BITS-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                cur_msb_q, cur_msb_d;
   logic [CNT_W-1:0]    cur_len_q, cur_len_d;

   logic                mode_msb_s;
   logic [CNT_W-1:0]    mode_len_s;
   logic [CNT_W-1:0]    shamt_s;
   logic [NUM_BITS-1:0] sr_shift_s;
   logic [NUM_BITS-1:0] mask_s;
   logic [NUM_BITS-1:0] word_s;
   logic                complete_s;

   // Shift register, bit counter and latched word mode.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sr_q      <= SR_RESET;
         cnt_q     <= {CNT_W{1'b0}};
         cur_msb_q <= DIR_MSB;
         cur_len_q <= LEN_RESET;
      end else begin
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         cur_msb_q <= cur_msb_d;
         cur_len_q <= cur_len_d;
      end
   end

   // The first bit of a word picks up the live mode inputs; later bits use the latch.
   always_comb begin
      if (cnt_q == {CNT_W{1'b0}}) begin
         mode_msb_s = msb_first;
         mode_len_s = CNT_W'(sanitise_len(int'(word_len), NUM_BITS));
      end else begin
         mode_msb_s = cur_msb_q;
         mode_len_s = cur_len_q;
      end

      if (mode_msb_s == DIR_MSB) begin
         sr_shift_s = {sr_q[NUM_BITS-2:0], serial_in};
      end else begin
         sr_shift_s = {serial_in, sr_q[NUM_BITS-1:1]};
      end

      shamt_s = LEN_RESET - mode_len_s;
      mask_s  = {NUM_BITS{1'b1}} >> shamt_s;
      if (mode_msb_s == DIR_MSB) begin
         word_s = sr_shift_s & mask_s;
      end else begin
         word_s = (sr_shift_s >> shamt_s) & mask_s;
      end

      complete_s = shift_enable && !clear && (cnt_q == (mode_len_s - CNT_W'(1)));
   end

   // Next-state: clear wins over a shift in the same cycle.
   always_comb begin
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      cur_msb_d = cur_msb_q;
      cur_len_d = cur_len_q;
      if (clear) begin
         sr_d      = SR_RESET;
         cnt_d     = {CNT_W{1'b0}};
         cur_msb_d = DIR_MSB;
         cur_len_d = LEN_RESET;
      end else if (shift_enable) begin
         sr_d      = sr_shift_s;
         cur_msb_d = mode_msb_s;
         cur_len_d = mode_len_s;
         if (complete_s) begin
            cnt_d = {CNT_W{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         sr_d = sr_q;
      end
   end

   flex_stp_hold #(
      .WIDTH (NUM_BITS)
   ) u_hold (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear_i   (clear),
      .load_i    (complete_s),
      .data_i    (word_s),
      .ready_i   (word_ready),
      .data_o    (word_out),
      .valid_o   (word_valid),
      .overrun_o (overrun)
   );

   assign parallel_live = sr_q;
   assign bit_cnt       = cnt_q;

endmodule

// File: tb/tb_flex_stp_deser.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a bit-queue reference model of the deserialiser.
module tb_flex_stp_deser;

   localparam int NB = 8;
   localparam int CW = $clog2(NB + 1);

   logic          clk = 1'b0;
   logic          n_rst, clear, shift_enable, serial_in, msb_first, word_ready;
   logic [CW-1:0] word_len;
   logic [NB-1:0] parallel_live, word_out;
   logic [CW-1:0] bit_cnt;
   logic          word_valid, overrun;

   always #5 clk = ~clk;

   flex_stp_deser #(
      .NUM_BITS  (NB),
      .RESET_BIT (1'b1)
   ) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear),
      .shift_enable  (shift_enable),
      .serial_in     (serial_in),
      .msb_first     (msb_first),
      .word_len      (word_len),
      .word_ready    (word_ready),
      .parallel_live (parallel_live),
      .bit_cnt       (bit_cnt),
      .word_out      (word_out),
      .word_valid    (word_valid),
      .overrun       (overrun)
   );

   // Reference model: bits of the current word in arrival order plus the output slot.
   bit            m_bits[$];
   bit            m_msb;
   int            m_len;
   logic [NB-1:0] m_sr;
   logic [NB-1:0] m_word;
   logic          m_valid, m_ovr;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("parallel_live", 32'(parallel_live), 32'(m_sr));
      chk("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
      chk("word_out", 32'(word_out), 32'(m_word));
      chk("word_valid", 32'(word_valid), 32'(m_valid));
      chk("overrun", 32'(overrun), 32'(m_ovr));
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_sr    = '1;
      m_word  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   // First bit received lands in the highest word position for MSB-first, bit 0 otherwise.
   function automatic logic [NB-1:0] assemble();
      int w = 0;
      for (int i = 0; i < m_len; i++) begin
         if (m_msb) w = w | (int'(m_bits[i]) << (m_len - 1 - i));
         else       w = w | (int'(m_bits[i]) << i);
      end
      return NB'(w);
   endfunction

   task automatic model_step(input bit se, input bit sin, input bit msb, input int len,
                             input bit rdy, input bit clr);
      bit            done = 1'b0;
      logic [NB-1:0] w    = '0;
      if (clr) begin
         m_bits.delete();
         m_sr    = '1;
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end else begin
         if (se) begin
            if (m_bits.size() == 0) begin
               m_msb = msb;
               m_len = (len == 0 || len > NB) ? NB : len;
            end
            m_bits.push_back(sin);
            m_sr = m_msb ? {m_sr[NB-2:0], sin} : {sin, m_sr[NB-1:1]};
            if (m_bits.size() == m_len) begin
               w    = assemble();
               done = 1'b1;
               m_bits.delete();
            end
         end
         m_ovr = 1'b0;
         if (done) begin
            if (!m_valid || rdy) begin
               m_word  = w;
               m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_valid && rdy) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic cyc(input bit se, input bit sin, input bit msb, input int len,
                      input bit rdy, input bit clr);
      shift_enable = se;
      serial_in    = sin;
      msb_first    = msb;
      word_len     = CW'(len);
      word_ready   = rdy;
      clear        = clr;
      @(posedge clk);
      model_step(se, sin, msb, len, rdy, clr);
      #1;
      check_all();
   endtask

   // Sends n bits of v, either most-significant bit first or least-significant first.
   task automatic send(input logic [NB-1:0] v, input int n, input bit hi_first,
                       input bit msb, input int len, input bit rdy);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, hi_first ? v[n-1-i] : v[i], msb, len, rdy, 1'b0);
      end
   endtask

   task automatic apply_reset();
      n_rst        = 1'b0;
      shift_enable = 1'b0;
      clear        = 1'b0;
      #2;
      model_reset();
      check_all();
      @(negedge clk);
      n_rst = 1'b1;
      #1;
   endtask

   initial begin
      logic [NB-1:0] seq = 8'h78;
      n_rst = 1'b0; clear = 1'b0; shift_enable = 1'b0; serial_in = 1'b0;
      msb_first = 1'b1; word_len = '0; word_ready = 1'b1;
      model_reset();
      m_msb = 1'b1;
      m_len = NB;

      // 1: reset state
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("rst_live", 32'(parallel_live), 32'h0000_00FF);
      @(negedge clk);
      n_rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b0);

      // 2: MSB-first 0x78, bit counter walks 1..7 then 0
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, seq[7-i], 1'b1, 8, 1'b1, 1'b0);
         chk("cnt_walk", 32'(bit_cnt), 32'((i + 1) % 8));
      end
      chk("t2_valid", 32'(word_valid), 32'd1);
      chk("t2_word", 32'(word_out), 32'h78);
      cyc(1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b0);
      chk("t2_drain", 32'(word_valid), 32'd0);

      // 3: same bits LSB-first, msb_first toggled after the third bit
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, seq[7-i], (i < 3) ? 1'b0 : 1'b1, 8, 1'b1, 1'b0);
      end
      chk("t3_word", 32'(word_out), 32'h1E);
      cyc(1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b0);

      // 4: short word then word_len=0 treated as full width
      send(8'h0B, 4, 1'b0, 1'b0, 4, 1'b1);
      chk("t4_word", 32'(word_out), 32'h0B);
      chk("t4_valid", 32'(word_valid), 32'd1);
      chk("t4_cnt", 32'(bit_cnt), 32'd0);
      send(8'hFF, 8, 1'b0, 1'b0, 0, 1'b1);
      chk("t4_len0", 32'(word_out), 32'hFF);
      cyc(1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b0);

      // 5: overrun when the slot is full and not drained
      send(8'h78, 8, 1'b1, 1'b1, 8, 1'b0);
      send(8'h1E, 8, 1'b1, 1'b1, 8, 1'b0);
      chk("t5_ovr", 32'(overrun), 32'd1);
      chk("t5_keep", 32'(word_out), 32'h78);
      cyc(1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0);
      chk("t5_ovr_end", 32'(overrun), 32'd0);
      chk("t5_valid", 32'(word_valid), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b0);
      chk("t5_drain", 32'(word_valid), 32'd0);

      // 6: clear beats shift, reset mid-word, then a clean word
      send(8'h05, 3, 1'b1, 1'b1, 8, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 8, 1'b1, 1'b1);
      chk("t6_clr_cnt", 32'(bit_cnt), 32'd0);
      chk("t6_clr_live", 32'(parallel_live), 32'hFF);
      send(8'h15, 5, 1'b1, 1'b1, 8, 1'b1);
      apply_reset();
      chk("t6_rst_live", 32'(parallel_live), 32'hFF);
      send(8'hA5, 8, 1'b1, 1'b1, 8, 1'b1);
      chk("t6_word", 32'(word_out), 32'hA5);

      // Randomized traffic with occasional clears and mid-run resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(499, 0) == 0) begin
            apply_reset();
         end else begin
            cyc(1'($urandom_range(3, 0) != 0), 1'($urandom), 1'($urandom),
                int'($urandom_range(15, 0)), 1'($urandom_range(2, 0) == 0),
                1'($urandom_range(99, 0) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
